fifo_uart_tx: RTL

Read-side consumer for sync_fifo: drains bytes from the FIFO's show-ahead read port and serialises each one as an asynchronous UART frame on a single tx line. The frame is start bit, WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between a sync_fifo instance and the chip pad. It owns the FIFO's rd_en and never reads while the FIFO reports empty.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/fifo_uart_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Contents: tx_state_t (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4),
//           cnt_width() for sizing the baud counter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Width of a counter that runs 0..n-1. Floors at 1 bit so a degenerate
  // parameter never produces a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a show-ahead read port.
// Latency: write visible on rd_data/empty the cycle after wr_en; read pops on the rd_en edge.
// Backpressure: writes while full and reads while empty are ignored.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_data   : push interface
//   rd_en, rd_data   : pop interface, rd_data valid whenever !empty
//   empty, full      : status flags
//   count            : current occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  // DEPTH must be a power of two so pointers wrap naturally.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final count.
// Latency: tick is combinational from the registered count; clear takes effect next cycle.
// Backpressure: none; free-running unless clear is held.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 on the next edge
//   tick       : 1 on the last cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each word as a UART frame
// (start, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits).
// Latency: tx goes low the cycle after the fifo_rd_en edge; frame = bits*CLKS_PER_BIT cycles.
// Backpressure: reads only when tx_en && !fifo_empty and the serialiser is free;
//               back-to-back frames are chained from the last stop cycle with no idle gap.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tx_en        : permission to start new frames
//   fifo_empty   : FIFO empty flag
//   fifo_data    : FIFO show-ahead data
//   fifo_rd_en   : one-cycle pop pulse to the FIFO
//   tx           : serial line, idle high, registered
//   busy         : frame in progress, registered
//   frame_done   : pulse on the last cycle of the final stop bit
//   frame_count  : completed frames, wraps at 2^16
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t        state;
  tx_state_t        state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [BW-1:0]    bit_idx;
  logic [BW-1:0]    bit_n;
  logic             par_bit;
  logic             par_n;
  logic             tx_n;
  logic             ready;
  logic             baud_clr;
  logic             baud_tick;
  logic             last_stop;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clr),
    .tick  (baud_tick)
  );

  // ready is low during reset and for the first cycle after it, so an IDLE
  // state under reset can never pop a word that would then be lost.
  assign last_stop  = (state == ST_STOP) && baud_tick && (bit_idx == LAST_STOP);
  assign frame_done = last_stop;
  assign fifo_rd_en = ready && tx_en && !fifo_empty &&
                      ((state == ST_IDLE) || last_stop);

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bit_n    = bit_idx;
    par_n    = par_bit;
    baud_clr = 1'b0;

    unique case (state)
      ST_IDLE: begin
        baud_clr = 1'b1;
      end
      ST_START: begin
        if (baud_tick) begin
          state_n = ST_DATA;
          bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shreg_n = shreg >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_n = ST_STOP;
          bit_n   = '0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_idx == LAST_STOP) begin
            state_n  = ST_IDLE;
            baud_clr = 1'b1;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        baud_clr = 1'b1;
      end
    endcase

    // Load overrides everything: from IDLE or from the final stop cycle.
    if (fifo_rd_en) begin
      state_n  = ST_START;
      shreg_n  = fifo_data;
      par_n    = (^fifo_data) ^ (PARITY_ODD != 0);
      bit_n    = '0;
      baud_clr = 1'b1;
    end

    // tx is registered from the next state so the line changes exactly on
    // the bit-period boundary.
    unique case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      par_bit     <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frame_count <= 16'd0;
      ready       <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_n;
      par_bit <= par_n;
      tx      <= tx_n;
      busy    <= (state_n != ST_IDLE);
      ready   <= 1'b1;
      if (last_stop) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
